// File: rtl/cfa_pkg.sv
// Shared definitions for the Bayer demosaic path: colour/pattern codes,
// scan FSM states and the CFA site-colour decode.
package cfa_pkg;

  localparam logic [1:0] GREEN = 2'b01;
  localparam logic [1:0] RED   = 2'b10;
  localparam logic [1:0] BLUE  = 2'b11;

  localparam logic [1:0] PAT_RGGB = 2'b00;
  localparam logic [1:0] PAT_GRBG = 2'b01;
  localparam logic [1:0] PAT_GBRG = 2'b10;
  localparam logic [1:0] PAT_BGGR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Every phase is RGGB with the row and/or column parity flipped.
  function automatic logic [1:0] site_colour(input logic [1:0] pattern,
                                             input logic row_lsb,
                                             input logic col_lsb);
    logic r;
    logic c;
    case (pattern)
      PAT_RGGB: begin r = row_lsb;  c = col_lsb;  end
      PAT_GRBG: begin r = row_lsb;  c = ~col_lsb; end
      PAT_GBRG: begin r = ~row_lsb; c = col_lsb;  end
      default:  begin r = ~row_lsb; c = ~col_lsb; end
    endcase
    if (r ^ c)   return GREEN;
    else if (!r) return RED;
    else         return BLUE;
  endfunction

endpackage

// File: rtl/cfa_line_buffer.sv
// Two-row delay line: returns the samples one and two rows above the write
// column; reads are asynchronous and see the pre-write contents.
module cfa_line_buffer #(
  parameter int DATA_W   = 12,
  parameter int MAX_COLS = 2048,
  parameter int AW       = 12
) (
  input  logic              clk,
  input  logic              advance,
  input  logic [AW-1:0]     col,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] row1,
  output logic [DATA_W-1:0] row2
);

  logic [DATA_W-1:0] mem1 [0:MAX_COLS];
  logic [DATA_W-1:0] mem2 [0:MAX_COLS];

  assign row1 = mem1[col];
  assign row2 = mem2[col];

  always_ff @(posedge clk) begin
    if (advance) begin
      mem1[col] <= wdata;
      mem2[col] <= mem1[col];
    end
  end

endmodule

// File: rtl/cfa_bilinear_stream.sv
// Streaming 3x3 bilinear Bayer demosaic with pad-row/column flush.
// Border policy: define CFA_BORDER_MIRROR_EN for mirrored edges, else zero-fill.
module cfa_bilinear_stream
  import cfa_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int ROW_W    = 11,
  parameter int COL_W    = 11,
  parameter int MAX_COLS = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_W-1:0]  rows_max,
  input  logic [COL_W-1:0]  cols_max,
  input  logic [1:0]        pattern,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              busy,
  output logic              done
);

  localparam int SR_W  = ROW_W + 1;
  localparam int SC_W  = COL_W + 1;
  localparam int SUM_W = DATA_W + 2;
  localparam int H_W   = DATA_W + 1;

  state_t            state;
  logic              drain_cnt;
  logic [ROW_W-1:0]  rows_q;
  logic [COL_W-1:0]  cols_q;
  logic [1:0]        pat_q;
  logic [SR_W-1:0]   sr;
  logic [SC_W-1:0]   sc;
  logic [DATA_W-1:0] win [3][3];
  logic              win_valid;
  logic [ROW_W-1:0]  crow;
  logic [COL_W-1:0]  ccol;

  logic              is_real, advance, col_end, last_pos, start_ok;
  logic [DATA_W-1:0] sample, lb_row1, lb_row2;

  // A transfer happens when in_valid && in_ready at a rising edge; in_ready
  // depends only on state, never on in_valid. Pad positions need no transfer.
  assign is_real  = (sr <= {1'b0, rows_q}) && (sc <= {1'b0, cols_q});
  assign in_ready = (state == ST_SCAN) && is_real;
  assign advance  = (state == ST_SCAN) && (!is_real || in_valid);
  assign sample   = is_real ? in_data : '0;
  assign col_end  = (sc == ({1'b0, cols_q} + SC_W'(1)));
  assign last_pos = col_end && (sr == ({1'b0, rows_q} + SR_W'(1)));
  assign start_ok = start && (rows_max != '0) && (cols_max != '0) &&
                    ({1'b0, cols_max} <= SC_W'(MAX_COLS - 1));

  cfa_line_buffer #(
    .DATA_W  (DATA_W),
    .MAX_COLS(MAX_COLS),
    .AW      (SC_W)
  ) u_lb (
    .clk    (clk),
    .advance(advance),
    .col    (sc),
    .wdata  (sample),
    .row1   (lb_row1),
    .row2   (lb_row2)
  );

  logic              top_miss, bot_miss, left_miss, right_miss;
  logic [DATA_W-1:0] vw [3][3];
  logic [DATA_W-1:0] nb [3][3];

  always_comb begin
    top_miss   = (crow == '0);
    bot_miss   = (crow == rows_q);
    left_miss  = (ccol == '0);
    right_miss = (ccol == cols_q);
    for (int j = 0; j < 3; j++) begin
`ifdef CFA_BORDER_MIRROR_EN
      vw[0][j] = top_miss ? win[2][j] : win[0][j];
      vw[2][j] = bot_miss ? win[0][j] : win[2][j];
`else
      vw[0][j] = top_miss ? '0 : win[0][j];
      vw[2][j] = bot_miss ? '0 : win[2][j];
`endif
      vw[1][j] = win[1][j];
    end
    for (int i = 0; i < 3; i++) begin
`ifdef CFA_BORDER_MIRROR_EN
      nb[i][0] = left_miss  ? vw[i][2] : vw[i][0];
      nb[i][2] = right_miss ? vw[i][0] : vw[i][2];
`else
      nb[i][0] = left_miss  ? '0 : vw[i][0];
      nb[i][2] = right_miss ? '0 : vw[i][2];
`endif
      nb[i][1] = vw[i][1];
    end
  end

  logic [DATA_W-1:0] q_cross, q_diag, q_h, q_v;
  logic [DATA_W-1:0] pix_r, pix_g, pix_b;
  logic [1:0]        ctr_col, h_col;

  assign q_cross = DATA_W'((SUM_W'(nb[0][1]) + SUM_W'(nb[2][1]) + SUM_W'(nb[1][0]) +
                            SUM_W'(nb[1][2]) + SUM_W'(2)) >> 2);
  assign q_diag  = DATA_W'((SUM_W'(nb[0][0]) + SUM_W'(nb[0][2]) + SUM_W'(nb[2][0]) +
                            SUM_W'(nb[2][2]) + SUM_W'(2)) >> 2);
  assign q_h     = DATA_W'((H_W'(nb[1][0]) + H_W'(nb[1][2]) + H_W'(1)) >> 1);
  assign q_v     = DATA_W'((H_W'(nb[0][1]) + H_W'(nb[2][1]) + H_W'(1)) >> 1);

  always_comb begin
    ctr_col = site_colour(pat_q, crow[0], ccol[0]);
    h_col   = site_colour(pat_q, crow[0], ~ccol[0]);
    pix_r   = nb[1][1];
    pix_g   = nb[1][1];
    pix_b   = nb[1][1];
    case (ctr_col)
      RED: begin
        pix_g = q_cross;
        pix_b = q_diag;
      end
      BLUE: begin
        pix_g = q_cross;
        pix_r = q_diag;
      end
      default: begin
        pix_r = (h_col == RED) ? q_h : q_v;
        pix_b = (h_col == RED) ? q_v : q_h;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      drain_cnt <= 1'b0;
      rows_q    <= '0;
      cols_q    <= '0;
      pat_q     <= '0;
      sr        <= '0;
      sc        <= '0;
      win_valid <= 1'b0;
      crow      <= '0;
      ccol      <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_row   <= '0;
      out_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else begin
      if (done) busy <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state  <= ST_SCAN;
            rows_q <= rows_max;
            cols_q <= cols_max;
            pat_q  <= pattern;
            sr     <= '0;
            sc     <= '0;
            busy   <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (advance) begin
            if (last_pos) begin
              state     <= ST_DRAIN;
              drain_cnt <= 1'b0;
            end
            if (col_end) begin
              sc <= '0;
              sr <= sr + SR_W'(1);
            end else begin
              sc <= sc + SC_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) state <= ST_IDLE;
          else           drain_cnt <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase

      // Window columns: 0 = oldest; rows: 0 = two rows up, 2 = current row.
      win_valid <= 1'b0;
      if (advance) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb_row2;
        win[1][2] <= lb_row1;
        win[2][2] <= sample;
        if (sr != '0 && sc != '0) begin
          win_valid <= 1'b1;
          crow      <= ROW_W'(sr - SR_W'(1));
          ccol      <= COL_W'(sc - SC_W'(1));
        end
      end

      out_valid <= win_valid;
      done      <= win_valid && (crow == rows_q) && (ccol == cols_q);
      if (win_valid) begin
        out_r   <= pix_r;
        out_g   <= pix_g;
        out_b   <= pix_b;
        out_row <= crow;
        out_col <= ccol;
      end
    end
  end

endmodule

// File: tb/tb_cfa_bilinear_stream.sv
// Bench for cfa_bilinear_stream: directed frames, per-pixel model from the
// neighbourhood rules, literal pins on selected pixels.
module tb_cfa_bilinear_stream;

  localparam int DATA_W   = 12;
  localparam int ROW_W    = 11;
  localparam int COL_W    = 11;
  localparam int MAX_COLS = 2048;
  localparam int W        = 1 + ROW_W + COL_W + 3 * DATA_W;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, in_ready, out_valid, busy, done;
  logic [ROW_W-1:0]  rows_max, out_row;
  logic [COL_W-1:0]  cols_max, out_col;
  logic [1:0]        pattern;
  logic [DATA_W-1:0] in_data, out_r, out_g, out_b;

  always #5 clk = ~clk;

  cfa_bilinear_stream #(
    .DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W), .MAX_COLS(MAX_COLS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rows_max(rows_max), .cols_max(cols_max),
    .pattern(pattern), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;
  logic [W-1:0] exp_q[$];
  int img[16][16];
  logic [3*DATA_W-1:0] cap[16][16];

  // ---------------- reference model ----------------
  function automatic int pix(int r, int c, int rm, int cm);
`ifdef CFA_BORDER_MIRROR_EN
    if (r < 0) r = 1;
    if (r > rm) r = rm - 1;
    if (c < 0) c = 1;
    if (c > cm) c = cm - 1;
`else
    if (r < 0 || r > rm || c < 0 || c > cm) return 0;
`endif
    return img[r][c];
  endfunction

  function automatic byte colour_at(int pat, int r, int c);
    string s;
    case (pat)
      0: s = "RGGB";
      1: s = "GRBG";
      2: s = "GBRG";
      default: s = "BGGR";
    endcase
    return s[(r % 2) * 2 + (c % 2)];
  endfunction

  task automatic model_frame(int rm, int cm, int pat);
    for (int r = 0; r <= rm; r++) begin
      for (int c = 0; c <= cm; c++) begin
        int n, s, w, e, ctr, dg, er, eg, eb;
        byte k;
        ctr = img[r][c];
        n = pix(r - 1, c, rm, cm);
        s = pix(r + 1, c, rm, cm);
        w = pix(r, c - 1, rm, cm);
        e = pix(r, c + 1, rm, cm);
        dg = pix(r - 1, c - 1, rm, cm) + pix(r - 1, c + 1, rm, cm) +
             pix(r + 1, c - 1, rm, cm) + pix(r + 1, c + 1, rm, cm);
        k = colour_at(pat, r, c);
        if (k == "R") begin
          er = ctr; eg = (n + s + w + e + 2) / 4; eb = (dg + 2) / 4;
        end else if (k == "B") begin
          eb = ctr; eg = (n + s + w + e + 2) / 4; er = (dg + 2) / 4;
        end else begin
          eg = ctr;
          if (colour_at(pat, r, c + 1) == "R") begin
            er = (w + e + 1) / 2; eb = (n + s + 1) / 2;
          end else begin
            eb = (w + e + 1) / 2; er = (n + s + 1) / 2;
          end
        end
        exp_q.push_back({(r == rm && c == cm) ? 1'b1 : 1'b0, ROW_W'(r), COL_W'(c),
                         DATA_W'(er), DATA_W'(eg), DATA_W'(eb)});
      end
    end
  endtask

  task automatic fill_flat(int v);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        img[r][c] = v;
  endtask

  task automatic fill_layout(int pat);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        case (colour_at(pat, r, c))
          "R": img[r][c] = 400;
          "G": img[r][c] = 200;
          default: img[r][c] = 100;
        endcase
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        img[r][c] = (r * 293 + c * 157 + 11) % 4096;
  endtask

  // ---------------- scoreboard / compare process ----------------
  logic [W-1:0] sb_exp, sb_got;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        total++;
        sb_got = {done, out_row, out_col, out_r, out_g, out_b};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out row=%0d col=%0d r=%0d g=%0d b=%0d",
                   out_row, out_col, out_r, out_g, out_b);
        end else begin
          sb_exp = exp_q.pop_front();
          if (sb_got !== sb_exp) begin
            bad++;
            $display("FAIL pixel got done/row/col/r/g/b=%0d/%0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d/%0d",
                     done, out_row, out_col, out_r, out_g, out_b,
                     sb_exp[W-1], sb_exp[W-2 -: ROW_W], sb_exp[W-2-ROW_W -: COL_W],
                     sb_exp[3*DATA_W-1 -: DATA_W], sb_exp[2*DATA_W-1 -: DATA_W],
                     sb_exp[DATA_W-1:0]);
          end
        end
        if (out_row < 16 && out_col < 16) cap[out_row][out_col] = {out_r, out_g, out_b};
      end else if (done) begin
        total++;
        bad++;
        $display("FAIL done_without_valid got=1 required=0");
      end
      if (in_ready && !busy) begin
        bad++;
        $display("FAIL ready_while_idle got=1 required=0");
      end
      if (in_valid && in_ready) acc_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int got, int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic pin(string name, int r, int c, int er, int eg, int eb);
    logic [3*DATA_W-1:0] v;
    v = cap[r][c];
    check({name, "_r"}, int'(v[3*DATA_W-1 -: DATA_W]), er);
    check({name, "_g"}, int'(v[2*DATA_W-1 -: DATA_W]), eg);
    check({name, "_b"}, int'(v[DATA_W-1:0]), eb);
  endtask

  // Start pulse, then scramble the frame inputs: they must already be latched.
  task automatic do_start(int rm, int cm, int pat);
    rows_max = ROW_W'(rm);
    cols_max = COL_W'(cm);
    pattern  = 2'(pat);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    rows_max = '1;
    cols_max = COL_W'(5);
    pattern  = ~pattern;
  endtask

  task automatic send_pixels(int rm, int cm, bit gap, int stop_after);
    int n;
    n = 0;
    for (int r = 0; r <= rm; r++) begin
      for (int c = 0; c <= cm; c++) begin
        bit ok;
        int guard;
        if (n == stop_after) begin
          in_valid = 1'b0;
          return;
        end
        if (gap) begin
          in_valid = 1'b0;
          tick();
        end
        in_valid = 1'b1;
        in_data  = DATA_W'(img[r][c]);
        guard = 0;
        do begin
          @(negedge clk);
          ok = in_ready;
          tick();
          guard++;
        end while (!ok && guard < 200);
        if (!ok) begin
          total++;
          bad++;
          $display("FAIL accept_timeout row=%0d col=%0d got=0 required=1", r, c);
          in_valid = 1'b0;
          return;
        end
        n++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(int rm, int cm);
    int guard;
    bit seen;
    guard = 0;
    seen  = 1'b0;
    while (!seen && guard < 2000) begin
      @(negedge clk);
      seen = done;
      tick();
      guard++;
    end
    check("done_seen", int'(seen), 1);
    in_valid = 1'b0;
    @(negedge clk);
    check("busy_after_done", int'(busy), 0);
    check("queue_drained", exp_q.size(), 0);
    check("accepted_count", acc_cnt, (rm + 1) * (cm + 1));
    tick();
  endtask

  // Extra in_valid after the last pixel must not be consumed on pad positions.
  task automatic run_frame(int rm, int cm, int pat, bit gap);
    acc_cnt = 0;
    model_frame(rm, cm, pat);
    do_start(rm, cm, pat);
    send_pixels(rm, cm, gap, 1 << 20);
    in_valid = 1'b1;
    in_data  = '1;
    wait_done(rm, cm);
  endtask

  task automatic idle_checks(string name, int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check({name, "_busy"}, int'(busy), 0);
      check({name, "_ready"}, int'(in_ready), 0);
      tick();
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    rows_max = '0; cols_max = '0; pattern = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_rgb", int'({out_r, out_g, out_b}), 0);
    check("rst_rowcol", int'({out_row, out_col}), 0);
    tick();
    rst = 1'b0;
    tick();

    // Illegal frame sizes are ignored.
    do_start(3, 0, 0);
    idle_checks("bad_cols", 6);
    do_start(0, 3, 0);
    idle_checks("bad_rows", 6);

    // Flat 4x4 field.
    fill_flat(100);
    run_frame(3, 3, 0, 1'b0);
`ifdef CFA_BORDER_MIRROR_EN
    pin("flat_00", 0, 0, 100, 100, 100);
    pin("flat_33", 3, 3, 100, 100, 100);
`else
    pin("flat_00", 0, 0, 100, 50, 25);
    pin("flat_33", 3, 3, 25, 50, 100);
`endif
    pin("flat_11", 1, 1, 100, 100, 100);

    // Two-level colour layouts in all four phases.
    for (int p = 0; p < 4; p++) begin
      fill_layout(p);
      run_frame(5, 5, p, 1'b0);
      pin("lay_22", 2, 2, 400, 200, 100);
      pin("lay_33", 3, 3, 400, 200, 100);
`ifdef CFA_BORDER_MIRROR_EN
      pin("lay_00", 0, 0, 400, 200, 100);
`else
      if (p == 0) pin("lay_00_rggb", 0, 0, 400, 100, 25);
      if (p == 3) pin("lay_00_bggr", 0, 0, 100, 100, 100);
`endif
    end

    // Varied data, continuous then with in_valid gaps.
    fill_ramp();
    run_frame(5, 5, 2, 1'b0);
    run_frame(5, 5, 2, 1'b1);

    // Abort on the 10th accepted input of a wide frame, then a clean frame.
    acc_cnt = 0;
    do_start(3, 15, 0);
    send_pixels(3, 15, 1'b0, 10);
    check("abort_accepted", acc_cnt, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_out_valid", int'(out_valid), 0);
    tick();
    idle_checks("abort_idle", 8);
    run_frame(3, 3, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
